mips_control_register_scoreboard: RTL and testbench
===================================================

// Module: mips_control_register_scoreboard
// PURPOSE
//  Parametrised register-hazard scoreboard for the decode/issue stage of the pipelined core.
//  - Tracks in-flight destination registers with per-register pending counters.
//  - Raises issueReady only when the issuing instruction's sources and destination are hazard-free.
//  - Sits between the register-control signal generator (write addr/source/enable) and the issue stage.
//  - Generalises the fixed single-write control with configurable depth, register count and forwarding mode.
// PARAMETERS
//  ADDR_W       5  register address width; NUM_REGS = 2**ADDR_W
//  CNT_W        2  pending-counter width per register; max pending writes per reg = 2**CNT_W-1
//  FORWARD_ALU  1  1: ALU-sourced pending writes do not stall readers (bypass exists); 0: all pending writes stall
// PORTS
//  clock          input   1       rising-edge clock
//  reset          input   1       synchronous, active-high reset
//  issueValid     input   1       decode presents an instruction
//  issueReady     output  1       instruction may issue this cycle (combinational)
//  src1Used       input   1       port-1 source is read
//  src1Addr       input   ADDR_W  port-1 source address (Rs, or Rt for shifts)
//  src2Used       input   1       port-2 source is read
//  src2Addr       input   ADDR_W  port-2 source address (Rt)
//  writeEnable    input   1       instruction writes a register
//  writeAddr      input   ADDR_W  destination address (Rd or Rt)
//  writeIsLoad    input   1       write data source is Memory (0 = Alu)
//  retireValid    input   1       writeback stage completes a register write
//  retireAddr     input   ADDR_W  address being written back
//  retireIsLoad   input   1       the retiring write was memory-sourced
//  flush          input   1       discard all in-flight writes (branch/jump redirect)
//  inFlight       output  ADDR_W+CNT_W  total outstanding tracked writes
//  underflowErr   output  1       sticky: retire seen for a register with zero pending
// BEHAVIOUR
//  - State: per register r: pend[r] (CNT_W), load[r] (CNT_W, load[r] <= pend[r]); inFlight; underflowErr.
//  - Reset (sync, active-high): all pend/load = 0, inFlight = 0, underflowErr = 0; issueReady then follows comb rules.
//  - Register 0 never tracked: writes/retires to addr 0 change nothing; source addr 0 never hazards.
//  - blocking(a) = (FORWARD_ALU ? load[a] != 0 : pend[a] != 0), a != 0.
//  - Retire bypass: if retireValid and retireAddr == a and the retire drops the blocking count to 0, a is not blocking this cycle.
//  - issueReady = !flush && !(src1Used && blocking(src1Addr)) && !(src2Used && blocking(src2Addr))
//      && !(writeEnable && writeAddr != 0 && pend[writeAddr] == max && !(retireValid && retireAddr == writeAddr)).
//  - issueReady independent of issueValid; fire = issueValid && issueReady.
//  - On fire with writeEnable, writeAddr != 0: pend += 1; load += 1 if writeIsLoad; inFlight += 1.
//  - On retireValid, retireAddr != 0: if pend > 0: pend -= 1, load -= 1 if retireIsLoad and load > 0, inFlight -= 1;
//      if pend == 0: no count change, underflowErr <= 1.
//  - Fire and retire same register same cycle: net counts unchanged (inc and dec cancel per counter).
//  - Fire and retire different registers: both applied; inFlight net change -1/0/+1.
//  - flush: next cycle all pend/load = 0, inFlight = 0; overrides fire and retire in the same cycle; underflowErr kept.
//  - underflowErr cleared only by reset.
//  - Counters never wrap: issue stalls at max; decrement never below 0.
//  - Latency: counter updates visible to issueReady the cycle after fire/retire (plus same-cycle retire bypass).
// TESTING
//  - Reset: assert reset 2 cycles -> inFlight=0, underflowErr=0, issueReady=1 for any valid issue.
//  - Load-use: issue lw $8 (writeIsLoad=1); next cycle add reading $8 -> issueReady=0 until retire $8 isLoad=1; ready same cycle as retire.
//  - ALU forward: FORWARD_ALU=1, issue add $9, then sub reads $9 -> issueReady=1; with FORWARD_ALU=0 -> issueReady=0 until retire $9.
//  - Saturation: CNT_W=2, three issues writing $5 with no retire -> 4th issue writing $5 has issueReady=0; retire $5 same cycle -> ready=1, pend stays 3.
//  - Flush: 4 writes in flight, flush with simultaneous fire -> next cycle inFlight=0, all pend=0, fired write not tracked.
//  - Underflow/$0: retire $7 with pend=0 -> underflowErr=1 and sticky; issue writing $0 -> inFlight unchanged.

Source files
------------

// File: rtl/mips_control_register_scoreboard.sv
// Register-hazard scoreboard for decode/issue: per-register pending-write counters
// gate issueReady on source/destination hazards and saturation.
module mips_control_register_scoreboard #(
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 2,
  parameter int FORWARD_ALU = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issueValid,
  output logic                      issueReady,
  input  logic                      src1Used,
  input  logic [ADDR_W-1:0]         src1Addr,
  input  logic                      src2Used,
  input  logic [ADDR_W-1:0]         src2Addr,
  input  logic                      writeEnable,
  input  logic [ADDR_W-1:0]         writeAddr,
  input  logic                      writeIsLoad,
  input  logic                      retireValid,
  input  logic [ADDR_W-1:0]         retireAddr,
  input  logic                      retireIsLoad,
  input  logic                      flush,
  output logic [ADDR_W+CNT_W-1:0]   inFlight,
  output logic                      underflowErr
);

  localparam int NUM_REGS = 2**ADDR_W;
  localparam int IF_W     = ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] pend_q [NUM_REGS];
  logic [CNT_W-1:0] pend_d [NUM_REGS];
  logic [CNT_W-1:0] load_q [NUM_REGS];
  logic [CNT_W-1:0] load_d [NUM_REGS];
  logic [IF_W-1:0]  in_flight_q, in_flight_d;
  logic             underflow_q, underflow_d;

  logic blk1, blk2, sat, fire, wr_en, ret_en, ret_ok;
  logic inc, dec, inc_l, dec_l;

  // A register blocks readers while its relevant count is non-zero, unless the
  // write retiring this very cycle is the last one that would block it.
  function automatic logic is_blocking(input logic [ADDR_W-1:0] a,
                                       input logic [CNT_W-1:0]  pend_a,
                                       input logic [CNT_W-1:0]  load_a,
                                       input logic              ret_hit,
                                       input logic              ret_load);
    logic [CNT_W-1:0] cnt;
    logic             drops;
    cnt   = (FORWARD_ALU != 0) ? load_a : pend_a;
    drops = ret_hit && (cnt == CNT_W'(1)) && ((FORWARD_ALU == 0) || ret_load);
    return (a != '0) && (cnt != '0) && !drops;
  endfunction

  // Handshake: an instruction issues (fire) on any cycle where issueValid and
  // issueReady are both high; issueReady never looks at issueValid, and
  // decode must hold the instruction steady until it fires.
  always_comb begin
    blk1 = src1Used && is_blocking(src1Addr, pend_q[src1Addr], load_q[src1Addr],
                                   retireValid && (retireAddr == src1Addr), retireIsLoad);
    blk2 = src2Used && is_blocking(src2Addr, pend_q[src2Addr], load_q[src2Addr],
                                   retireValid && (retireAddr == src2Addr), retireIsLoad);
    sat  = writeEnable && (writeAddr != '0) && (pend_q[writeAddr] == CNT_MAX)
           && !(retireValid && (retireAddr == writeAddr));
    issueReady = !flush && !blk1 && !blk2 && !sat;

    fire   = issueValid && issueReady;
    wr_en  = fire && writeEnable && (writeAddr != '0);
    ret_en = retireValid && (retireAddr != '0);
    ret_ok = ret_en && (pend_q[retireAddr] != '0);

    inc   = 1'b0;
    dec   = 1'b0;
    inc_l = 1'b0;
    dec_l = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc   = wr_en && (writeAddr == ADDR_W'(r));
      dec   = ret_ok && (retireAddr == ADDR_W'(r));
      inc_l = inc && writeIsLoad && (load_q[r] != CNT_MAX);
      dec_l = dec && retireIsLoad && (load_q[r] != '0);
      if (r == 0 || flush) begin
        pend_d[r] = '0;
        load_d[r] = '0;
      end else begin
        pend_d[r] = pend_q[r] + CNT_W'(inc) - CNT_W'(dec);
        load_d[r] = load_q[r] + CNT_W'(inc_l) - CNT_W'(dec_l);
      end
    end

    in_flight_d = flush ? '0 : (in_flight_q + IF_W'(wr_en) - IF_W'(ret_ok));
    underflow_d = underflow_q | (ret_en && (pend_q[retireAddr] == '0));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_q[r] <= '0;
        load_q[r] <= '0;
      end
      in_flight_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      load_q      <= load_d;
      in_flight_q <= in_flight_d;
      underflow_q <= underflow_d;
    end
  end

  assign inFlight     = in_flight_q;
  assign underflowErr = underflow_q;

endmodule

// File: tb/tb_mips_control_register_scoreboard.sv
// Directed bench: two scoreboards (ALU forwarding on/off) share one stimulus
// stream; each step checks issueReady, inFlight and underflowErr against hand values.
module tb_mips_control_register_scoreboard;

  logic       clock = 1'b0;
  logic       reset;
  logic       issueValid, src1Used, src2Used, writeEnable, writeIsLoad;
  logic       retireValid, retireIsLoad, flush;
  logic [4:0] src1Addr, src2Addr, writeAddr, retireAddr;

  logic       rdy_f, rdy_n, uf_f, uf_n;
  logic [6:0] inf_f, inf_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mips_control_register_scoreboard #(.ADDR_W(5), .CNT_W(2), .FORWARD_ALU(1)) dut (
    .clock(clock), .reset(reset), .issueValid(issueValid), .issueReady(rdy_f),
    .src1Used(src1Used), .src1Addr(src1Addr), .src2Used(src2Used), .src2Addr(src2Addr),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeIsLoad(writeIsLoad),
    .retireValid(retireValid), .retireAddr(retireAddr), .retireIsLoad(retireIsLoad),
    .flush(flush), .inFlight(inf_f), .underflowErr(uf_f)
  );

  mips_control_register_scoreboard #(.ADDR_W(5), .CNT_W(2), .FORWARD_ALU(0)) dut_nf (
    .clock(clock), .reset(reset), .issueValid(issueValid), .issueReady(rdy_n),
    .src1Used(src1Used), .src1Addr(src1Addr), .src2Used(src2Used), .src2Addr(src2Addr),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeIsLoad(writeIsLoad),
    .retireValid(retireValid), .retireAddr(retireAddr), .retireIsLoad(retireIsLoad),
    .flush(flush), .inFlight(inf_n), .underflowErr(uf_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    issueValid = 0; src1Used = 0; src2Used = 0; writeEnable = 0; writeIsLoad = 0;
    retireValid = 0; retireIsLoad = 0; flush = 0;
    src1Addr = 0; src2Addr = 0; writeAddr = 0; retireAddr = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_w(input logic [4:0] wa, input logic is_ld);
    issueValid = 1; writeEnable = 1; writeAddr = wa; writeIsLoad = is_ld;
  endtask

  task automatic retire(input logic [4:0] ra, input logic is_ld);
    retireValid = 1; retireAddr = ra; retireIsLoad = is_ld;
  endtask

  initial begin
    // reset
    idle();
    reset = 1;
    tick(); tick();
    chk("reset_inflight_f", inf_f, 0);
    chk("reset_inflight_n", inf_n, 0);
    chk("reset_uf_f", uf_f, 0);
    chk("reset_uf_n", uf_n, 0);
    reset = 0;
    src1Used = 1; src1Addr = 3; src2Used = 1; src2Addr = 4;
    writeEnable = 1; writeAddr = 6;
    #1;
    chk("reset_ready_f", rdy_f, 1);
    chk("reset_ready_n", rdy_n, 1);
    tick();

    // load-use: lw $8 then add reading $8
    idle(); issue_w(5'd8, 1'b1); #1;
    chk("lw_ready_f", rdy_f, 1);
    chk("lw_ready_n", rdy_n, 1);
    tick();
    chk("lw_inflight_f", inf_f, 1);
    chk("lw_inflight_n", inf_n, 1);
    idle(); issue_w(5'd10, 1'b0);
    src1Used = 1; src1Addr = 8; src2Used = 1; src2Addr = 9; #1;
    chk("use_stall_f", rdy_f, 0);
    chk("use_stall_n", rdy_n, 0);
    tick();
    chk("use_stall2_f", rdy_f, 0);
    chk("use_stall2_n", rdy_n, 0);
    chk("use_stall_inflight_f", inf_f, 1);
    retire(5'd8, 1'b1); #1;
    chk("use_bypass_f", rdy_f, 1);
    chk("use_bypass_n", rdy_n, 1);
    tick();
    chk("use_fire_inflight_f", inf_f, 1);
    chk("use_fire_inflight_n", inf_n, 1);

    // ALU forwarding: sub reads $10 (ALU write in flight)
    idle(); issue_w(5'd11, 1'b0); src1Used = 1; src1Addr = 10; #1;
    chk("fwd_ready_f", rdy_f, 1);
    chk("fwd_ready_n", rdy_n, 0);
    tick();
    chk("fwd_inflight_f", inf_f, 2);
    chk("fwd_inflight_n", inf_n, 1);
    idle(); src1Used = 1; src1Addr = 10; retire(5'd10, 1'b0); #1;
    chk("fwd_bypass_f", rdy_f, 1);
    chk("fwd_bypass_n", rdy_n, 1);
    tick();
    chk("fwd_ret_inflight_f", inf_f, 1);
    chk("fwd_ret_inflight_n", inf_n, 0);
    idle(); flush = 1; issue_w(5'd11, 1'b0); #1;
    chk("flush_ready_f", rdy_f, 0);
    chk("flush_ready_n", rdy_n, 0);
    tick();
    chk("flush1_inflight_f", inf_f, 0);
    chk("flush1_inflight_n", inf_n, 0);

    // saturation on $5
    for (int i = 0; i < 3; i++) begin
      idle(); issue_w(5'd5, 1'b0); #1;
      chk("sat_fill_ready_f", rdy_f, 1);
      chk("sat_fill_ready_n", rdy_n, 1);
      tick();
    end
    chk("sat_inflight_f", inf_f, 3);
    chk("sat_inflight_n", inf_n, 3);
    idle(); issue_w(5'd5, 1'b0); #1;
    chk("sat_stall_f", rdy_f, 0);
    chk("sat_stall_n", rdy_n, 0);
    tick();
    chk("sat_stall_inflight_f", inf_f, 3);
    retire(5'd5, 1'b0); #1;
    chk("sat_bypass_f", rdy_f, 1);
    chk("sat_bypass_n", rdy_n, 1);
    tick();
    chk("sat_cancel_inflight_f", inf_f, 3);
    chk("sat_cancel_inflight_n", inf_n, 3);
    idle(); issue_w(5'd5, 1'b0); #1;
    chk("sat_still_full_f", rdy_f, 0);
    idle(); src1Used = 1; src1Addr = 5; #1;
    chk("sat_read_f", rdy_f, 1);
    chk("sat_read_n", rdy_n, 0);

    // flush with a simultaneous issue attempt
    idle(); issue_w(5'd12, 1'b1); #1;
    chk("fl_pre_ready_f", rdy_f, 1);
    tick();
    chk("fl_pre_inflight_f", inf_f, 4);
    chk("fl_pre_inflight_n", inf_n, 4);
    idle(); flush = 1; issue_w(5'd13, 1'b0); #1;
    chk("fl_ready_f", rdy_f, 0);
    tick();
    chk("fl_inflight_f", inf_f, 0);
    chk("fl_inflight_n", inf_n, 0);
    idle(); src1Used = 1; src1Addr = 5; src2Used = 1; src2Addr = 12;
    writeEnable = 1; writeAddr = 5; #1;
    chk("fl_clear_ready_f", rdy_f, 1);
    chk("fl_clear_ready_n", rdy_n, 1);

    // underflow and register 0
    idle(); #1;
    chk("uf_before_f", uf_f, 0);
    retire(5'd7, 1'b0);
    tick();
    chk("uf_set_f", uf_f, 1);
    chk("uf_set_n", uf_n, 1);
    chk("uf_inflight_f", inf_f, 0);
    idle(); tick(); tick();
    chk("uf_sticky_f", uf_f, 1);
    chk("uf_sticky_n", uf_n, 1);
    issue_w(5'd0, 1'b1); #1;
    chk("r0_ready_f", rdy_f, 1);
    tick();
    chk("r0_inflight_f", inf_f, 0);
    chk("r0_inflight_n", inf_n, 0);

    // fire and retire on different registers
    idle(); issue_w(5'd20, 1'b0); tick();
    chk("mix_inc_inflight_f", inf_f, 1);
    idle(); issue_w(5'd21, 1'b1); retire(5'd20, 1'b0); tick();
    chk("mix_net0_inflight_f", inf_f, 1);
    chk("mix_net0_inflight_n", inf_n, 1);
    idle(); retire(5'd21, 1'b1); tick();
    chk("mix_dec_inflight_f", inf_f, 0);
    chk("mix_dec_inflight_n", inf_n, 0);

    // reset clears the sticky error
    idle(); reset = 1; tick(); reset = 0; #1;
    chk("rst2_uf_f", uf_f, 0);
    chk("rst2_uf_n", uf_n, 0);
    chk("rst2_inflight_f", inf_f, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
